router_fsm: RTL
===============

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have no parameters; state encoding is internal and free.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: pkt_valid  in  1  source packet-valid strobe.
REQ-005 SHALL have ports: data_in  in  2  header address bits [1:0]; 0/1/2 valid, 3 invalid.
REQ-006 SHALL have ports: fifo_full  in  1  full flag of the currently addressed output FIFO.
REQ-007 SHALL have ports: fifo_empty_0/1/2  in  1 each  empty flags of output FIFOs 0..2.
REQ-008 SHALL have ports: soft_reset_0/1/2  in  1 each  per-port timeout soft reset.
REQ-009 SHALL have ports: parity_done, low_pkt_valid  in  1 each  status from router_reg.
REQ-010 SHALL have ports: detect_add, lfd_state, ld_state, laf_state, full_state  out  1 each  state strobes to router_reg.
REQ-011 SHALL have ports: write_enb_reg  out  1  FIFO write enable; rst_int_reg  out  1  clear internal parity regs; busy  out  1  source stall.

Function
REQ-012 SHALL implement eight states: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
REQ-013 SHALL latch data_in into a 2-bit addr register on any clock in DECODE_ADDRESS with pkt_valid=1.
REQ-014 DECODE_ADDRESS: pkt_valid & data_in!=3 & fifo_empty[data_in]=1 -> LOAD_FIRST_DATA; pkt_valid & data_in!=3 & fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY; otherwise stay.
REQ-015 WAIT_TILL_EMPTY: fifo_empty[addr]=1 -> LOAD_FIRST_DATA; else stay.
REQ-016 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly one cycle).
REQ-017 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay; fifo_full has priority.
REQ-018 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-019 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else LOAD_DATA.
REQ-020 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-021 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-022 soft_reset_[addr]=1 in any state except DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle, overriding REQ-014..021; soft resets of other ports SHALL be ignored.
REQ-023 Outputs SHALL be Moore, decoded from current state only: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-024 write_enb_reg SHALL be 1 in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY; 0 otherwise.
REQ-025 busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA, 1 in all other states.
REQ-026 Exactly one of the six state strobes of REQ-023 SHALL be 1, except in WAIT_TILL_EMPTY and LOAD_PARITY where all are 0.
REQ-027 Illegal state encodings SHALL return to DECODE_ADDRESS on the next clock.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force DECODE_ADDRESS and addr=2'b00, independent of clk.
REQ-029 During and after reset: detect_add=1, busy=0, all other outputs 0.
REQ-030 rst asserted mid-packet SHALL abandon the packet; no state SHALL persist past reset.

Verification
REQ-031 Reset then pkt_valid=1, data_in=2'b01, fifo_empty_1=1 -> states DECODE, LFD, LOAD_DATA on consecutive edges; write_enb_reg=1 from LFD cycle; busy=1 only in LFD.
REQ-032 Header addr 2, fifo_empty_2=0 for 4 cycles -> WAIT_TILL_EMPTY 4 cycles with busy=1, write_enb_reg=0; then LFD.
REQ-033 In LOAD_DATA, fifo_full=1 for 3 cycles -> full_state=1 3 cycles, then laf_state=1 one cycle; parity_done=0, low_pkt_valid=0 -> back to LOAD_DATA.
REQ-034 8-byte payload then pkt_valid=0 -> LOAD_PARITY (write_enb_reg=1, busy=1) then CHECK_PARITY_ERROR (rst_int_reg=1) then DECODE_ADDRESS.
REQ-035 Header data_in=2'b11 with pkt_valid=1 -> remains DECODE_ADDRESS, write_enb_reg=0 throughout.
REQ-036 Addr 0 in FIFO_FULL_STATE, soft_reset_1=1 -> no change; soft_reset_0=1 -> DECODE_ADDRESS next edge; rst=0 mid-LOAD_DATA -> detect_add=1 before next clk edge.

Source files
------------

// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
// router_fsm : header decode / load / parity sequencing control for a
//              three-port packet router, Moore-decoded strobes to router_reg.
// Revision   : 1.0
// ============================================================================
module router_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd1;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd2;
    localparam logic [2:0] LOAD_DATA          = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] LOAD_PARITY        = 3'd6;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

    logic [2:0] state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] empty_vec;
    logic [3:0] srst_vec;

    // Index 3 is the invalid address; padding keeps every select in range.
    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    addr_d = data_in;
                    if (data_in != 2'b11) begin
                        state_d = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_vec[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // Timeout on the port being loaded aborts the packet from any active state.
        if (state_q != DECODE_ADDRESS && srst_vec[addr_q]) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = lfd_state || ld_state || laf_state || (state_q == LOAD_PARITY);
    assign busy          = !(detect_add || ld_state);

endmodule
`default_nettype wire
